// File: rtl/mfrc522_reg_arbiter.sv
// ---------------------------------------------------------------------------
// mfrc522_reg_arbiter
//
// Shares one 16-bit SPI frame engine between two register-access requesters.
// Each accepted request becomes a single MFRC522 register frame. The block
// enforces an idle gap between frames, aborts frames that never complete, and
// after reset runs a one-shot VersionReg probe so the top level can tell
// whether a reader is fitted.
//
// Ports
//   clk_25mhz, rst      clock, asynchronous active-high reset
//   reqN_valid/write/addr/wdata   command from requester N (N = 0, 1)
//   reqN_ready          one-cycle accept pulse
//   rspN_valid/rdata/err           one-cycle response, err = timeout
//   frame_start/frame_tx           launch a frame on the SPI engine
//   frame_done/frame_rx            end-of-frame pulse and received bytes
//   probe_done/version/version_ok  result of the startup probe (sticky)
//   busy                state is anything other than IDLE
// ---------------------------------------------------------------------------
module mfrc522_reg_arbiter #(
  parameter int unsigned STARTUP_CYCLES = 250000,
  parameter int unsigned GAP_CYCLES     = 25,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [5:0]  VERSION_ADDR   = 6'h37
) (
  input  logic        clk_25mhz,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [5:0]  req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [7:0]  rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [5:0]  req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [7:0]  rsp1_rdata,
  output logic        rsp1_err,
  output logic        frame_start,
  output logic [15:0] frame_tx,
  input  logic        frame_done,
  input  logic [15:0] frame_rx,
  output logic        probe_done,
  output logic [7:0]  version,
  output logic        version_ok,
  output logic        busy
);

  // One shared counter serves startup delay, frame timeout and gap timing.
  localparam int unsigned MAX_A = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int          CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  localparam logic [2:0] ST_STARTUP    = 3'd0;
  localparam logic [2:0] ST_PROBE      = 3'd1;
  localparam logic [2:0] ST_PROBE_WAIT = 3'd2;
  localparam logic [2:0] ST_IDLE       = 3'd3;
  localparam logic [2:0] ST_ISSUE      = 3'd4;
  localparam logic [2:0] ST_WAIT       = 3'd5;
  localparam logic [2:0] ST_RESPOND    = 3'd6;
  localparam logic [2:0] ST_GAP        = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic             write_q, write_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_tx_q, frame_tx_d;
  logic             probe_done_q, probe_done_d;
  logic [7:0]       version_q, version_d;
  logic             version_ok_q, version_ok_d;
  logic             busy_q, busy_d;

  // Only the low received byte carries register data.
  logic unused_rx_hi;
  assign unused_rx_hi = ^frame_rx[15:8];

  // ---------------- arbitration ----------------
  logic       accept_open;
  logic       grant_any;
  logic       pick1;
  logic       sel_write;
  logic [5:0] sel_addr;
  logic [7:0] sel_wdata;

  always_comb begin
    accept_open = (state_q == ST_IDLE) && probe_done_q;
    grant_any   = accept_open && (req0_valid || req1_valid);
    // Requester 1 wins when it is alone, or on a tie when 0 was served last.
    pick1       = req1_valid && (!req0_valid || !last_grant_q);
    sel_write   = pick1 ? req1_write : req0_write;
    sel_addr    = pick1 ? req1_addr  : req0_addr;
    sel_wdata   = pick1 ? req1_wdata : req0_wdata;
  end

  assign req0_ready = grant_any && !pick1;
  assign req1_ready = grant_any && pick1;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    write_d       = write_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    frame_start_d = 1'b0;
    frame_tx_d    = frame_tx_q;
    probe_done_d  = probe_done_q;
    version_d     = version_q;
    version_ok_d  = version_ok_q;

    case (state_q)
      ST_STARTUP: begin
        if (cnt_q == STARTUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_PROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PROBE: begin
        frame_start_d = 1'b1;
        frame_tx_d    = {1'b1, VERSION_ADDR, 1'b0, 8'h00};
        cnt_d         = '0;
        state_d       = ST_PROBE_WAIT;
      end
      ST_PROBE_WAIT: begin
        // The first cycle here is the frame_start cycle; the timeout
        // counter starts on the cycle after it, as it does for WAIT.
        if (frame_done) begin
          version_d    = frame_rx[7:0];
          version_ok_d = (frame_rx[7:0] == 8'h91) || (frame_rx[7:0] == 8'h92);
          probe_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_GAP;
        end else if (!frame_start_q) begin
          if (cnt_q == TIMEOUT_LAST) begin
            version_d    = 8'h00;
            version_ok_d = 1'b0;
            probe_done_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (grant_any) begin
          last_grant_d  = pick1;
          grant_d       = pick1;
          write_d       = sel_write;
          frame_tx_d    = {~sel_write, sel_addr, 1'b0, (sel_write ? sel_wdata : 8'h00)};
          frame_start_d = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last timeout cycle still counts as done.
        if (frame_done) begin
          rdata_d = write_q ? 8'h00 : frame_rx[7:0];
          err_d   = 1'b0;
          state_d = ST_RESPOND;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESPOND: begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STARTUP;
      end
    endcase

    // Registered so busy reads 0 while reset is held.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state_q       <= ST_STARTUP;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      write_q       <= 1'b0;
      rdata_q       <= 8'h00;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
      frame_tx_q    <= 16'h0000;
      probe_done_q  <= 1'b0;
      version_q     <= 8'h00;
      version_ok_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      write_q       <= write_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      frame_start_q <= frame_start_d;
      frame_tx_q    <= frame_tx_d;
      probe_done_q  <= probe_done_d;
      version_q     <= version_d;
      version_ok_q  <= version_ok_d;
      busy_q        <= busy_d;
    end
  end

  // ---------------- outputs ----------------
  logic responding;
  assign responding = (state_q == ST_RESPOND);

  assign rsp0_valid = responding && !grant_q;
  assign rsp1_valid = responding && grant_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : 8'h00;
  assign rsp1_rdata = rsp1_valid ? rdata_q : 8'h00;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;

  assign frame_start = frame_start_q;
  assign frame_tx    = frame_tx_q;
  assign probe_done  = probe_done_q;
  assign version     = version_q;
  assign version_ok  = version_ok_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mfrc522_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mfrc522_reg_arbiter
//
// Self-checking bench: a behavioural SPI engine answers frames after a
// programmable delay (or stays silent), and the main sequence checks frame
// words, response timing/data, round-robin order, gaps and reset behaviour.
// ---------------------------------------------------------------------------
module tb_mfrc522_reg_arbiter;

  localparam int STARTUP = 50;
  localparam int GAP     = 6;
  localparam int TO      = 512;

  logic clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  logic        rst;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
  logic [5:0]  req0_addr;
  logic [7:0]  req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
  logic [5:0]  req1_addr;
  logic [7:0]  req1_wdata, rsp1_rdata;
  logic        frame_start, frame_done;
  logic [15:0] frame_tx, frame_rx;
  logic        probe_done, version_ok, busy;
  logic [7:0]  version;

  mfrc522_reg_arbiter #(
    .STARTUP_CYCLES(STARTUP),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TO),
    .VERSION_ADDR  (6'h37)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .frame_start(frame_start),
    .frame_tx   (frame_tx),
    .frame_done (frame_done),
    .frame_rx   (frame_rx),
    .probe_done (probe_done),
    .version    (version),
    .version_ok (version_ok),
    .busy       (busy)
  );

  int cyc = 0;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int rel_cyc = 0;
  bit model_last = 1'b1;

  // ---------------- engine model ----------------
  int          eng_delay     = 1;
  logic [15:0] eng_rx        = 16'h0000;
  bit          eng_silent    = 1'b0;
  bit          eng_pending   = 1'b0;
  int          eng_count     = 0;
  int          last_done_cyc = -1;
  int          min_gap       = 1000000000;
  int          overlaps      = 0;

  initial begin
    frame_done = 1'b0;
    frame_rx   = 16'h0000;
    forever begin
      @(negedge clk_25mhz);
      frame_done = 1'b0;
      frame_rx   = 16'h0000;
      if (rst) begin
        eng_pending   = 1'b0;
        last_done_cyc = -1;
      end else if (frame_start) begin
        if (eng_pending) overlaps++;
        if (last_done_cyc >= 0 && (cyc - last_done_cyc) < min_gap) min_gap = cyc - last_done_cyc;
        eng_pending = !eng_silent;
        eng_count   = eng_delay;
      end else if (eng_pending) begin
        eng_count--;
        if (eng_count == 0) begin
          frame_done    = 1'b1;
          frame_rx      = eng_rx;
          eng_pending   = 1'b0;
          last_done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #(40 * 80000);
    $display("FAIL watchdog: cycle budget exhausted, observed cyc=%0d required < 80000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {14'd0, req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
            req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
            frame_start, frame_tx, probe_done, version, version_ok, busy};
  endfunction

  function automatic logic [15:0] exp_tx(input bit w, input logic [5:0] a, input logic [7:0] wd);
    return {~w, a, 1'b0, (w ? wd : 8'h00)};
  endfunction

  task automatic reset_probe(input logic [15:0] rx, input int delay, input bit silent, input string tag);
    int          at;
    int          pd_at;
    logic [15:0] tx;
    logic [7:0]  v;
    eng_rx = rx; eng_delay = delay; eng_silent = silent;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk_25mhz);
    check({tag, "_outs_in_reset"}, outs_vec(), 64'd0);
    rst = 1'b0;
    rel_cyc = cyc;
    model_last = 1'b1;
    at = -1; tx = 16'h0;
    for (int i = 0; i < STARTUP + 10; i++) begin
      @(negedge clk_25mhz);
      if (frame_start) begin at = cyc - rel_cyc; tx = frame_tx; break; end
    end
    check({tag, "_start_cycle"}, 64'(at), 64'(STARTUP + 1));
    check({tag, "_probe_tx"}, 64'(tx), 64'h EE00);
    pd_at = -1;
    for (int i = 0; i < TO + 50; i++) begin
      @(negedge clk_25mhz);
      if (probe_done) begin pd_at = cyc - rel_cyc; break; end
    end
    check({tag, "_done_cycle"}, 64'(pd_at), 64'(at + (silent ? TO : delay) + 1));
    v = silent ? 8'h00 : rx[7:0];
    check({tag, "_version"}, 64'(version), 64'(v));
    check({tag, "_version_ok"}, 64'(version_ok), 64'(v == 8'h91 || v == 8'h92));
    $display("[TB] probe %s rx=0x%04h silent=%0d -> version=0x%02h ok=%0d", tag, rx, silent, version, version_ok);
  endtask

  task automatic expect_txn(input bit n, input bit w, input logic [5:0] a, input logic [7:0] wd,
                            input logic [15:0] rx, input int delay, input bit silent,
                            input bit keep, input string tag);
    bit         got_rdy;
    int         start_c;
    int         rsp_c;
    bit         side;
    bit         other;
    logic [7:0] rd;
    logic       er;
    logic [7:0] exp_rd;
    eng_rx = rx; eng_delay = delay; eng_silent = silent;
    got_rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req0_ready || req1_ready) begin got_rdy = 1'b1; break; end
      @(negedge clk_25mhz);
    end
    check({tag, "_ready_seen"}, 64'(got_rdy), 64'd1);
    check({tag, "_ready_side"}, 64'({req1_ready, req0_ready}), 64'(n ? 2'b10 : 2'b01));
    @(negedge clk_25mhz);
    if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    check({tag, "_frame_start"}, 64'(frame_start), 64'd1);
    check({tag, "_frame_tx"}, 64'(frame_tx), 64'(exp_tx(w, a, wd)));
    start_c = cyc;
    rsp_c = -1; side = 1'b0; other = 1'b0; rd = 8'h00; er = 1'b0;
    for (int i = 0; i < TO + 100; i++) begin
      @(negedge clk_25mhz);
      if (rsp0_valid || rsp1_valid) begin
        rsp_c = cyc;
        side  = rsp1_valid;
        other = rsp1_valid ? rsp0_valid : rsp1_valid;
        rd    = rsp1_valid ? rsp1_rdata : rsp0_rdata;
        er    = rsp1_valid ? rsp1_err : rsp0_err;
        break;
      end
    end
    exp_rd = (silent || w) ? 8'h00 : rx[7:0];
    check({tag, "_rsp_latency"}, 64'(rsp_c - start_c), 64'((silent ? TO : delay) + 1));
    check({tag, "_rsp_side"}, 64'(side), 64'(n));
    check({tag, "_rsp_other_quiet"}, 64'(other), 64'd0);
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    check({tag, "_err"}, 64'(er), 64'(silent));
    model_last = n;
    $display("[TB] txn %s req%0d %s addr=0x%02h tx=0x%04h rdata=0x%02h err=%0d", tag, n,
             w ? "wr" : "rd", a, exp_tx(w, a, wd), rd, er);
  endtask

  task automatic single_req(input bit n, input bit w, input logic [5:0] a, input logic [7:0] wd,
                            input logic [15:0] rx, input int delay, input bit silent, input string tag);
    if (n) begin
      req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = wd;
    end else begin
      req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = wd;
    end
    expect_txn(n, w, a, wd, rx, delay, silent, 1'b0, tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit          rn;
    bit          rw;
    logic [5:0]  ra;
    logic [7:0]  rwd;
    logic [15:0] rrx;
    bit          exp_n;
    rst = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 6'h0; req0_wdata = 8'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 6'h0; req1_wdata = 8'h0;

    reset_probe(16'h0092, 400, 1'b0, "probe92");
    reset_probe(16'h00FF, 1 + int'($urandom_range(0, 40)), 1'b0, "probeFF");
    reset_probe(16'h0000, 1, 1'b1, "probe_silent");
    reset_probe(16'h0091, 5, 1'b0, "probe91");

    single_req(1'b0, 1'b0, 6'h11, 8'h00, 16'h003F, 1, 1'b0, "rd0_11");
    single_req(1'b1, 1'b1, 6'h2A, 8'h8D, 16'h5A5A, 3, 1'b0, "wr1_2A");

    for (int k = 0; k < 6; k++) begin
      rn  = 1'($urandom);
      rw  = 1'($urandom);
      ra  = 6'($urandom);
      rwd = 8'($urandom);
      rrx = 16'($urandom);
      single_req(rn, rw, ra, rwd, rrx, 1 + int'($urandom_range(0, 30)), 1'b0, $sformatf("rand%0d", k));
    end

    // Both requesters held valid: strict alternation from the last grant.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 6'($urandom); req0_wdata = 8'h00;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 6'($urandom); req1_wdata = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      exp_n = !model_last;
      rrx = 16'($urandom);
      if (exp_n) expect_txn(1'b1, req1_write, req1_addr, req1_wdata, rrx, 2 + int'($urandom_range(0, 20)), 1'b0, 1'b1, $sformatf("rr%0d", k));
      else       expect_txn(1'b0, req0_write, req0_addr, req0_wdata, rrx, 2 + int'($urandom_range(0, 20)), 1'b0, 1'b1, $sformatf("rr%0d", k));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("gap_min", 64'(min_gap >= GAP), 64'd1);
    check("no_overlap", 64'(overlaps), 64'd0);

    single_req(1'b0, 1'b0, 6'h05, 8'h00, 16'h1234, 1, 1'b1, "timeout_rd0");
    single_req(1'b1, 1'b0, 6'h06, 8'h00, 16'h00C3, 4, 1'b0, "after_to_rd1");

    // Reset in the middle of WAIT.
    eng_rx = 16'h00AA; eng_delay = 100; eng_silent = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 6'h09;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req0_ready) break;
      @(negedge clk_25mhz);
    end
    @(negedge clk_25mhz);
    req0_valid = 1'b0;
    check("midrst_frame_start", 64'(frame_start), 64'd1);
    repeat (10) @(negedge clk_25mhz);
    rst = 1'b1;
    #1;
    check("midrst_outs_immediate", outs_vec(), 64'd0);
    $display("[TB] reset asserted during WAIT");
    reset_probe(16'h0092, 7, 1'b0, "probe_rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
